fetch_controller: RTL and testbench
===================================

FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 Parameter WORD_SIZE, default 32, instruction width.
REQ-002 Parameter MEMORY_INDEX, default 32, ROM address / PC width.
REQ-003 Parameter PC_INIT_VALUE, default 0, PC loaded at reset.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset is asynchronous and active-low.
REQ-006 fetch_en  input  1  high permits new ROM requests.
REQ-007 redirect_valid  input  1  one-cycle pulse loading a new PC (branch/jump).
REQ-008 redirect_pc  input  MEMORY_INDEX  target PC, sampled when redirect_valid=1.
REQ-009 ProgramCounter  output  MEMORY_INDEX  ROM address, registered.
REQ-010 InstructionRegister  input  WORD_SIZE  ROM read data, valid one cycle after ProgramCounter is sampled.
REQ-011 instr_valid  output  1  instr/instr_pc hold a valid fetched instruction.
REQ-012 instr  output  WORD_SIZE  fetched instruction.
REQ-013 instr_pc  output  MEMORY_INDEX  address of instr.
REQ-014 instr_ready  input  1  decode accepts instr when instr_valid=1 and instr_ready=1.
REQ-015 busy  output  1  high when state != IDLE.

Function
REQ-016 States IDLE, RUN, DRAIN, encoded in one registered state variable.
REQ-017 IDLE -> RUN when fetch_en=1; RUN -> DRAIN when fetch_en=0 with a request in flight; RUN -> IDLE when fetch_en=0 with nothing in flight; DRAIN -> IDLE once the in-flight word is captured or flushed.
REQ-018 A request is issued in a cycle when state is RUN, fetch_en=1, no redirect, and the total of in-flight request, output register and skid entry after this cycle's pop is below 2.
REQ-019 On issue, ProgramCounter advances by 1 (word addressed) on the next edge, and the in-flight flag and its PC are recorded.
REQ-020 PC arithmetic is modulo 2^MEMORY_INDEX; all-ones + 1 wraps to 0 with no flag.
REQ-021 The in-flight word is captured one cycle after issue: into the output register if it is empty or popping this cycle, else into the 1-entry skid buffer.
REQ-022 On pop, the skid entry, if valid, moves to the output register in the same edge; FIFO order is preserved.
REQ-023 While instr_valid=1 and instr_ready=0, instr and instr_pc stay stable.
REQ-024 A redirect flushes the output register, skid entry and in-flight word, and loads ProgramCounter with redirect_pc on the same edge.
REQ-025 No instruction fetched before a redirect appears on instr after it.
REQ-026 The first instr_valid after a redirect is no earlier than 2 cycles later.
REQ-027 Redirect has priority over issue, capture and pop in the same cycle.
REQ-028 A redirect in IDLE loads ProgramCounter only and does not leave IDLE.
REQ-029 A redirect in DRAIN flushes and goes to IDLE.
REQ-030 The skid buffer never overflows; capture into a full skid entry is a design error (assertion).
REQ-031 Steady state with instr_ready=1 gives 1 instruction per cycle; latency is 2 cycles from ProgramCounter update to instr_valid.

Reset
REQ-032 While rst_n=0: ProgramCounter=PC_INIT_VALUE, state=IDLE, instr_valid=0, instr=0, instr_pc=0, busy=0, skid and in-flight flags cleared.
REQ-033 Reset asserted mid-fetch discards all in-flight and buffered words; none are presented after release.
REQ-034 The first request after reset release is issued from PC_INIT_VALUE.

Verification
REQ-035 ROM model word[i]=i; reset; fetch_en=1, instr_ready=1 -> instr=0,1,2,3... on consecutive cycles with instr_pc=instr.
REQ-036 Hold instr_ready=0 for 5 cycles mid-stream -> instr stable, ProgramCounter stops after 2 words buffered; on release, no word skipped or duplicated.
REQ-037 redirect_valid with redirect_pc=0x40 while skid full -> buffered words dropped; next instr=0x40, then 0x41.
REQ-038 redirect_pc=0xFFFFFFFE, run 4 words -> instr_pc sequence FFFFFFFE, FFFFFFFF, 0, 1.
REQ-039 Deassert fetch_en with one word in flight -> state DRAIN, that word delivered, then IDLE with busy=0.
REQ-040 Assert rst_n=0 asynchronously mid-stream -> outputs reach reset values immediately; after release, fetch restarts at 0.

Source files
------------

// File: rtl/fetch_controller.sv
// Instruction fetch front end. It issues word-addressed ROM requests,
// captures each returned word one cycle later, and presents it to decode
// through an output register backed by a one-entry skid buffer.
module fetch_controller #(
  parameter int unsigned WORD_SIZE = 32,
  parameter int unsigned MEMORY_INDEX = 32,
  parameter logic [MEMORY_INDEX-1:0] PC_INIT_VALUE = '0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    fetch_en,
  input  logic                    redirect_valid,
  input  logic [MEMORY_INDEX-1:0] redirect_pc,
  output logic [MEMORY_INDEX-1:0] ProgramCounter,
  input  logic [WORD_SIZE-1:0]    InstructionRegister,
  output logic                    instr_valid,
  output logic [WORD_SIZE-1:0]    instr,
  output logic [MEMORY_INDEX-1:0] instr_pc,
  input  logic                    instr_ready,
  output logic                    busy
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} fetchStateT;

  localparam logic [MEMORY_INDEX-1:0] PC_STEP = 1;

  fetchStateT              state, stateNext;
  logic                    inFlight;
  logic [MEMORY_INDEX-1:0] inFlightPc;
  logic                    skidValid;
  logic [WORD_SIZE-1:0]    skidInstr;
  logic [MEMORY_INDEX-1:0] skidPc;

  logic       pop, capture, issue, roomAfterPop;
  logic [1:0] occupancy;

  // Handshake, occupancy and issue decision; redirect masks issue and capture.
  always_comb begin
    pop          = instr_valid && instr_ready;
    occupancy    = 2'(inFlight) + 2'(instr_valid) + 2'(skidValid);
    roomAfterPop = pop ? (occupancy <= 2'd2) : (occupancy <= 2'd1);
    issue        = (state == RUN) && fetch_en && !redirect_valid && roomAfterPop;
    capture      = inFlight && !redirect_valid;
    busy         = (state != IDLE);
  end

  // Next-state logic; a redirect never pulls the block out of IDLE.
  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE:  if (fetch_en && !redirect_valid) stateNext = RUN;
      RUN: begin
        if (redirect_valid)  stateNext = fetch_en ? RUN : IDLE;
        else if (!fetch_en)  stateNext = inFlight ? DRAIN : IDLE;
      end
      DRAIN: if (redirect_valid || !inFlight) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= stateNext;
  end

  // PC and in-flight tracking; a redirect drops the pending word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ProgramCounter <= PC_INIT_VALUE;
      inFlight       <= 1'b0;
      inFlightPc     <= '0;
    end else if (redirect_valid) begin
      ProgramCounter <= redirect_pc;
      inFlight       <= 1'b0;
    end else begin
      inFlight <= issue;
      if (issue) begin
        ProgramCounter <= ProgramCounter + PC_STEP;
        inFlightPc     <= ProgramCounter;
      end
    end
  end

  // Output register plus skid entry, kept in FIFO order; redirect flushes both.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_valid <= 1'b0;
      instr       <= '0;
      instr_pc    <= '0;
      skidValid   <= 1'b0;
      skidInstr   <= '0;
      skidPc      <= '0;
    end else if (redirect_valid) begin
      instr_valid <= 1'b0;
      skidValid   <= 1'b0;
    end else if (pop) begin
      if (skidValid) begin
        instr     <= skidInstr;
        instr_pc  <= skidPc;
        skidValid <= capture;
        if (capture) begin
          skidInstr <= InstructionRegister;
          skidPc    <= inFlightPc;
        end
      end else begin
        instr_valid <= capture;
        if (capture) begin
          instr    <= InstructionRegister;
          instr_pc <= inFlightPc;
        end
      end
    end else if (capture) begin
      if (!instr_valid) begin
        instr_valid <= 1'b1;
        instr       <= InstructionRegister;
        instr_pc    <= inFlightPc;
      end else begin
        skidValid <= 1'b1;
        skidInstr <= InstructionRegister;
        skidPc    <= inFlightPc;
      end
    end
  end

  // The issue rule must keep a stalled, full pipe from ever receiving a third word.
  assert property (@(posedge clk) disable iff (!rst_n)
    !(capture && instr_valid && !instr_ready && skidValid));

endmodule

// File: tb/tb_fetch_controller.sv
// Randomized scoreboard bench for fetch_controller. The ROM returns word[i]=i.
// Expected delivery order is simply consecutive addresses from the last
// reset/redirect target; a monitor pops and compares on every accepted word.
module tb_fetch_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_en;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] ProgramCounter;
  logic [31:0] InstructionRegister;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic        busy;

  int nChecks = 0;
  int nErrors = 0;
  int totalPops = 0;
  logic [31:0] expQ[$];

  fetch_controller #(.WORD_SIZE(32), .MEMORY_INDEX(32), .PC_INIT_VALUE(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .ProgramCounter(ProgramCounter), .InstructionRegister(InstructionRegister),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .instr_ready(instr_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  // Synchronous ROM: word[i] = i, data one cycle after the address is sampled.
  always @(posedge clk) InstructionRegister <= ProgramCounter;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Expected stream after a reset or redirect: consecutive addresses, wrapping.
  task automatic refill(input logic [31:0] start);
    logic [31:0] v;
    expQ.delete();
    v = start;
    for (int i = 0; i < 4096; i++) begin
      expQ.push_back(v);
      v = v + 32'd1;
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkResetOutputs(input string tag);
    chk({tag, "_pc"}, ProgramCounter, 32'h0);
    chk({tag, "_valid"}, instr_valid, 1'b0);
    chk({tag, "_instr"}, instr, 32'h0);
    chk({tag, "_instr_pc"}, instr_pc, 32'h0);
    chk({tag, "_busy"}, busy, 1'b0);
  endtask

  // Monitor: scoreboard pops, hold-stability and post-redirect latency.
  logic        prevHold = 1'b0;
  logic [31:0] prevInstr, prevPc;
  int          sinceRedir = 0;
  logic        waitFirst = 1'b1;

  always @(negedge clk) begin
    if (!rst_n) begin
      prevHold   = 1'b0;
      sinceRedir = 0;
      waitFirst  = 1'b1;
    end else begin
      if (prevHold) begin
        chk("stall_valid", instr_valid, 1'b1);
        chk("stall_instr", instr, prevInstr);
        chk("stall_instr_pc", instr_pc, prevPc);
      end
      if (redirect_valid) begin
        sinceRedir = 0;
        waitFirst  = 1'b1;
        prevHold   = 1'b0;
      end else begin
        sinceRedir++;
        if (instr_valid && waitFirst) begin
          chk("redirect_latency_ge2", (sinceRedir >= 2), 1'b1);
          waitFirst = 1'b0;
        end
        if (instr_valid && instr_ready) begin
          totalPops++;
          if (expQ.size() == 0) begin
            chk("scoreboard_underflow", 1'b1, 1'b0);
          end else begin
            logic [31:0] e;
            e = expQ.pop_front();
            chk("instr_pc", instr_pc, e);
            chk("instr", instr, e);
          end
        end
        prevHold  = instr_valid && !instr_ready;
        prevInstr = instr;
        prevPc    = instr_pc;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int w, cnt;
    rst_n = 1'b0; fetch_en = 1'b0; redirect_valid = 1'b0;
    redirect_pc = 32'h0; instr_ready = 1'b0;
    refill(32'h0);
    #1;
    checkResetOutputs("reset");
    step(3);
    rst_n = 1'b1; fetch_en = 1'b1; instr_ready = 1'b1;

    // Streaming from 0: bounded wait for first word, then one word per cycle.
    w = 0;
    while (!instr_valid && w < 10) begin step(1); w++; end
    chk("first_valid", instr_valid, 1'b1);
    cnt = 0;
    for (int i = 0; i < 16; i++) begin step(1); cnt += int'(instr_valid); end
    chk("throughput", cnt, 16);

    // Stall 5 cycles: PC stops two words ahead of the presented word.
    instr_ready = 1'b0;
    step(5);
    chk("stall_pc_stop", ProgramCounter, instr_pc + 32'd2);
    instr_ready = 1'b1;
    step(6);

    // Redirect with skid full: buffered words dropped, 0x40 follows.
    instr_ready = 1'b0;
    step(3);
    redirect_valid = 1'b1; redirect_pc = 32'h40; refill(32'h40);
    step(1);
    redirect_valid = 1'b0; instr_ready = 1'b1;
    chk("redirect_pc_load", ProgramCounter, 32'h40);
    step(8);

    // Wrap-around through the top of the address space.
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFE; refill(32'hFFFF_FFFE);
    step(1);
    redirect_valid = 1'b0;
    step(8);

    // Drain: deassert fetch_en with a word in flight.
    fetch_en = 1'b0;
    step(1);
    chk("drain_busy", busy, 1'b1);
    step(1);
    chk("drain_idle_busy", busy, 1'b0);
    step(1);
    chk("drain_no_valid", instr_valid, 1'b0);
    chk("drain_all_delivered", expQ[0], ProgramCounter);

    // Redirect while idle loads the PC but stays idle.
    redirect_valid = 1'b1; redirect_pc = 32'h100; refill(32'h100);
    step(1);
    redirect_valid = 1'b0;
    chk("idle_redirect_busy", busy, 1'b0);
    chk("idle_redirect_pc", ProgramCounter, 32'h100);
    fetch_en = 1'b1;
    step(10);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      instr_ready = ($urandom_range(0, 3) != 0);
      fetch_en    = ($urandom_range(0, 15) != 0);
      if ($urandom_range(0, 30) == 0) begin
        logic [31:0] t;
        t = ($urandom_range(0, 1) == 0) ? $urandom() : (32'hFFFF_FFFF - 32'($urandom_range(0, 3)));
        redirect_valid = 1'b1; redirect_pc = t; refill(t);
      end
      step(1);
      redirect_valid = 1'b0;
    end

    // Asynchronous reset mid-stream.
    fetch_en = 1'b1; instr_ready = 1'b1;
    step(6);
    #2;
    rst_n = 1'b0;
    #1;
    checkResetOutputs("async_reset");
    refill(32'h0);
    step(3);
    rst_n = 1'b1;
    step(12);

    fetch_en = 1'b0;
    step(6);
    chk("pop_count_reasonable", (totalPops > 200), 1'b1);
    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule
